mul_unit: RTL and testbench

Sequential, iterative 32×32 unsigned multiplier that executes the MUL operation (ALUOp 3'b010), which the combinational ALU does not implement. It sits beside the ALU in the execute stage. It accepts the same A/B/ALUOp operands under a start/busy/done handshake, and returns the low word on the same Result/Zero convention as the ALU, plus the high word of the 64-bit product. Control stalls the pipeline while busy is high.

---
 rtl/mul_unit.sv | 131 +++++++++++++
 tb/tb_mul_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
//
// Iterative unsigned WIDTH x WIDTH multiplier that sits beside the ALU in the
// execute stage and services the MUL ALUOp. It is a radix-2 shift-add engine
// with a fixed latency of WIDTH cycles and no early termination.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request, sampled on each rising edge
//   A, B      unsigned multiplicand / multiplier
//   ALUOp     operation select; only MUL_OP starts a multiply
//   busy      high while a multiply is in flight (registered, safe as a stall)
//   done      one-cycle pulse in the cycle Result/ResultHi take a new value
//   Result    low word of A*B (registered, holds until the next completion)
//   ResultHi  high word of A*B (registered, holds until the next completion)
//   Zero      high when Result == 0 (ResultHi is not considered)
// -----------------------------------------------------------------------------
module mul_unit #(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] MUL_OP = 3'b010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q,  state_d;
    logic [CW-1:0]          count_q,  count_d;
    logic [2*WIDTH-1:0]     acc_q,    acc_d;
    logic [2*WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     prod_q,   prod_d;
    logic                   done_q,   done_d;

    // Partial product for the current step: the shifted multiplicand when the
    // multiplier's current LSB is set. The accumulator is double width, so the
    // sum can never overflow.
    logic [2*WIDTH-1:0]     addend;
    logic [2*WIDTH-1:0]     acc_sum;

    always_comb begin
        addend  = mplier_q[0] ? mcand_q : '0;
        acc_sum = acc_q + addend;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Requests with any other ALUOp are dropped without effect.
                if (start && (ALUOp == MUL_OP)) begin
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // start is deliberately ignored here so the in-flight operands
                // cannot be disturbed.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    // The last step's sum goes straight to the result register,
                    // so the product is visible in the cycle done is high.
                    prod_d  = acc_sum;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign Result   = prod_q[WIDTH-1:0];
    assign ResultHi = prod_q[2*WIDTH-1:WIDTH];
    assign Zero     = ~|prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit
//
// Self-checking bench for mul_unit. A transaction-level model (product computed
// with plain 64-bit arithmetic, a cycle count to completion) is compared against
// the DUT on every falling edge; directed tests additionally pin literal results
// and latencies.
// -----------------------------------------------------------------------------
module tb_mul_unit;

    localparam logic [2:0] MUL = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  ALUOp = '0;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [31:0] ResultHi;
    logic        Zero;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mul_unit #(.WIDTH(32), .MUL_OP(3'b010)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .ALUOp    (ALUOp),
        .busy     (busy),
        .done     (done),
        .Result   (Result),
        .ResultHi (ResultHi),
        .Zero     (Zero)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // An accepted request latches A*B; it completes on the 32nd edge after
    // acceptance, at which point the product becomes visible together with done.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_edges = 0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_res  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_edges <= 0;
            m_prod  <= '0;
            m_res   <= '0;
        end else if (m_busy) begin
            m_edges <= m_edges + 1;
            if (m_edges + 1 == 32) begin
                m_res  <= m_prod;
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start && ALUOp == MUL) begin
                m_prod  <= {32'b0, A} * {32'b0, B};
                m_busy  <= 1'b1;
                m_edges <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     64'(busy),     64'(m_busy));
            check("done",     64'(done),     64'(m_done));
            check("result",   64'(Result),   64'(m_res[31:0]));
            check("resulthi", 64'(ResultHi), 64'(m_res[63:32]));
            check("zero",     64'(Zero),     64'(m_res[31:0] == 32'd0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(negedge clk);
        A = a; B = b; ALUOp = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the falling edge right after acceptance; returns falling edges
    // until done is seen (32 for an undisturbed operation).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 45) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lo, input logic [31:0] hi, input logic z);
        int lat;
        issue(a, b, MUL);
        wait_done(lat);
        check({name, "_lat"}, 64'(lat), 64'd32);
        check({name, "_lo"},  64'(Result), 64'(lo));
        check({name, "_hi"},  64'(ResultHi), 64'(hi));
        check({name, "_z"},   64'(Zero), 64'(z));
        $display("txn %s: %0h * %0h -> hi=%0h lo=%0h lat=%0d", name, a, b, ResultHi, Result, lat);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        int lat2;
        int extra;
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        logic [63:0] exp_p;

        #1 rst = 1'b1;
        #1;
        check("rst_busy",   64'(busy),     64'd0);
        check("rst_done",   64'(done),     64'd0);
        check("rst_result", 64'(Result),   64'd0);
        check("rst_hi",     64'(ResultHi), 64'd0);
        check("rst_zero",   64'(Zero),     64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        run_lit("basic",  32'd3,          32'd5,          32'd15,        32'd0,          1'b0);
        run_lit("full",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 32'hFFFF_FFFE,  1'b0);
        run_lit("zlow",   32'h0001_0000,  32'h0001_0000,  32'd0,         32'd1,          1'b1);
        run_lit("zeroop", 32'd0,          32'h1234,       32'd0,         32'd0,          1'b1);
        run_lit("set15",  32'd3,          32'd5,          32'd15,        32'd0,          1'b0);

        // Wrong ALUOp: nothing happens.
        issue(32'd9, 32'd9, 3'b000);
        repeat (3) @(negedge clk);
        check("badop_busy", 64'(busy), 64'd0);
        check("badop_res",  64'(Result), 64'd15);
        $display("txn badop: busy=%0d result=%0h", busy, Result);

        // Start while busy is ignored.
        issue(32'd6, 32'd9, MUL);
        repeat (5) @(negedge clk);
        A = 32'd7; B = 32'd7; ALUOp = MUL; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("inflight_res", 64'(Result), 64'd54);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("inflight_nodone", 64'(extra), 64'd0);
        $display("txn inflight: 6*9 -> %0d, extra dones=%0d", Result, extra);

        // Reset mid-operation.
        issue(32'h1234, 32'h5678, MUL);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy),   64'd0);
        check("abort_done", 64'(done),   64'd0);
        check("abort_res",  64'(Result), 64'd0);
        check("abort_zero", 64'(Zero),   64'd1);
        $display("txn abort: busy=%0d result=%0h zero=%0d", busy, Result, Zero);
        @(negedge clk);
        rst = 1'b0;
        run_lit("post_rst", 32'd2, 32'd21, 32'd42, 32'd0, 1'b0);

        // Back-to-back: new start in the done cycle.
        issue(32'd6, 32'd7, MUL);
        wait_done(lat);
        check("b2b_first", 64'(Result), 64'd42);
        A = 32'd4; B = 32'd4; ALUOp = MUL; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat2 = 1;
        while (!done && lat2 < 45) begin
            @(negedge clk);
            lat2++;
        end
        check("b2b_gap", 64'(lat2), 64'd33);
        check("b2b_res", 64'(Result), 64'd16);
        $display("txn b2b: 6*7 then 4*4 -> %0d gap=%0d", Result, lat2);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            rop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : MUL;
            issue(ra, rb, rop);
            if (rop != MUL) begin
                repeat (3) @(negedge clk);
                check("rnd_idle", 64'(busy), 64'd0);
                $display("txn rnd %0d: op=%0d ignored", i, rop);
            end else begin
                exp_p = {32'b0, ra} * {32'b0, rb};
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 20)) @(negedge clk);
                    A = $urandom; B = $urandom; ALUOp = MUL; start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                wait_done(lat);
                check("rnd_done", 64'(done), 64'd1);
                check("rnd_prod", {ResultHi, Result}, exp_p);
                $display("txn rnd %0d: %0h * %0h -> %0h", i, ra, rb, {ResultHi, Result});
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
